// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan with dead time, blanking, frame snapshot and blink sequencing.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 1000,
    parameter int DEAD_CYCLES   = 2,
    parameter int BLINK_TOGGLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_blank_mask,
    input  logic                    i_blink_req,
    output logic [1:0]              o_bcd,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_blank,
    output logic                    o_blinking
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_TOGGLES + 1);
    typedef enum logic [1:0] {SCAN, BLINK_OFF, BLINK_ON} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [BW-1:0] pairs, pairs_nx;
    logic [2*NUM_DIGITS-1:0] snap_dig, dig_eff;
    logic [NUM_DIGITS-1:0] snap_mask, mask_eff, an_nx;
    logic pending, fs, lit;
    logic [1:0] bcd_nx;
    // cnt/idx hold the position presented on the coming edge; a frame starts at (0,0)
    assign fs = (cnt == '0) && (idx == '0);
    always_comb begin
        state_nx = state;
        pairs_nx = pairs;
        if (fs) begin
            if (pending || i_blink_req) begin
                state_nx = BLINK_OFF;
                pairs_nx = '0;
            end else if (state == BLINK_OFF) begin
                state_nx = BLINK_ON;
            end else if (state == BLINK_ON) begin
                state_nx = (pairs + BW'(1) < BW'(BLINK_TOGGLES)) ? BLINK_OFF : SCAN;
                pairs_nx = (pairs + BW'(1) < BW'(BLINK_TOGGLES)) ? pairs + BW'(1) : '0;
            end
        end
    end
    // The frame-start edge must already display the freshly captured inputs
    assign dig_eff  = fs ? i_digits : snap_dig;
    assign mask_eff = fs ? i_blank_mask : snap_mask;
    assign bcd_nx   = dig_eff[{idx, 1'b0} +: 2];
    assign lit      = (int'(cnt) >= DEAD_CYCLES) && !mask_eff[idx] && (state_nx != BLINK_OFF);
    assign an_nx    = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    assign cnt_nx   = (cnt == CW'(REFRESH_DIV - 1)) ? '0 : cnt + CW'(1);
    assign idx_nx   = (cnt != CW'(REFRESH_DIV - 1)) ? idx : (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SCAN;
            cnt        <= '0;
            idx        <= '0;
            pairs      <= '0;
            snap_dig   <= '0;
            snap_mask  <= '0;
            pending    <= 1'b0;
            o_bcd      <= 2'd0;
            o_an       <= '1;
            o_blank    <= 1'b1;
            o_blinking <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            pairs      <= pairs_nx;
            snap_dig   <= dig_eff;
            snap_mask  <= mask_eff;
            pending    <= fs ? 1'b0 : (pending | i_blink_req);
            o_bcd      <= bcd_nx;
            o_an       <= an_nx;
            o_blank    <= ~lit;
            o_blinking <= state_nx != SCAN;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan order, snapshot, masking, blink sequencing and reset.
module tb_seg_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] i_digits = 8'hE4;
    logic [3:0] i_blank_mask = 4'b0000;
    logic i_blink_req = 1'b0;
    logic [1:0] o_bcd;
    logic [3:0] o_an;
    logic o_blank, o_blinking;
    int e = 0;
    int passed = 0;
    int total = 0;

    seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2), .BLINK_TOGGLES(2)) dut (
        .clk(clk), .rst(rst), .i_digits(i_digits), .i_blank_mask(i_blank_mask),
        .i_blink_req(i_blink_req), .o_bcd(o_bcd), .o_an(o_an), .o_blank(o_blank), .o_blinking(o_blinking)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic go(input int k);
        while (e < k) tick();
    endtask

    task automatic chk(input string tag, input logic [3:0] an, input logic [1:0] bcd, input logic bl, input logic bk);
        logic [7:0] obs, exp;
        obs = {o_an, o_bcd, o_blank, o_blinking};
        exp = {an, bcd, bl, bk};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s edge %0d: an/bcd/blank/blinking observed %b/%0d/%b/%b expected %b/%0d/%b/%b",
                    tag, e, o_an, o_bcd, o_blank, o_blinking, an, bcd, bl, bk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("reset", 4'b1111, 2'd0, 1'b1, 1'b0);
        end
        rst = 1'b0;
        e = 0;
    endtask

    initial begin
        // scan order, snapshot, mask
        do_reset(3);
        go(1);  chk("dead_e1", 4'b1111, 2'd0, 1'b1, 1'b0);
        go(2);  chk("dead_e2", 4'b1111, 2'd0, 1'b1, 1'b0);
        go(3);  chk("d0_e3", 4'b1110, 2'd0, 1'b0, 1'b0);
        go(8);  chk("d0_e8", 4'b1110, 2'd0, 1'b0, 1'b0);
        go(9);  chk("dead_e9", 4'b1111, 2'd1, 1'b1, 1'b0);
        go(11); chk("d1_e11", 4'b1101, 2'd1, 1'b0, 1'b0);
        i_digits = 8'h1B;
        go(16); chk("snap_e16", 4'b1101, 2'd1, 1'b0, 1'b0);
        go(19); chk("snap_e19", 4'b1011, 2'd2, 1'b0, 1'b0);
        go(27); chk("d3_e27", 4'b0111, 2'd3, 1'b0, 1'b0);
        go(32); chk("d3_e32", 4'b0111, 2'd3, 1'b0, 1'b0);
        go(35); chk("f1_d0", 4'b1110, 2'd3, 1'b0, 1'b0);
        i_blank_mask = 4'b0100;
        go(43); chk("f1_d1", 4'b1101, 2'd2, 1'b0, 1'b0);
        go(51); chk("f1_d2_nomask", 4'b1011, 2'd1, 1'b0, 1'b0);
        go(59); chk("f1_d3", 4'b0111, 2'd0, 1'b0, 1'b0);
        go(67); chk("mask_d0", 4'b1110, 2'd3, 1'b0, 1'b0);
        go(83); chk("mask_d2", 4'b1111, 2'd1, 1'b1, 1'b0);
        go(91); chk("mask_d3", 4'b0111, 2'd0, 1'b0, 1'b0);
        // single blink request
        i_digits = 8'hE4;
        i_blank_mask = 4'b0000;
        do_reset(1);
        go(9); i_blink_req = 1'b1;
        go(10); i_blink_req = 1'b0;
        go(32);  chk("pre_blink", 4'b0111, 2'd3, 1'b0, 1'b0);
        go(33);  chk("blink_start", 4'b1111, 2'd0, 1'b1, 1'b1);
        go(35);  chk("f1_off", 4'b1111, 2'd0, 1'b1, 1'b1);
        go(59);  chk("f1_off_d3", 4'b1111, 2'd3, 1'b1, 1'b1);
        go(67);  chk("f2_on", 4'b1110, 2'd0, 1'b0, 1'b1);
        go(99);  chk("f3_off", 4'b1111, 2'd0, 1'b1, 1'b1);
        go(131); chk("f4_on", 4'b1110, 2'd0, 1'b0, 1'b1);
        go(161); chk("scan_resume", 4'b1111, 2'd0, 1'b1, 1'b0);
        go(163); chk("scan_lit", 4'b1110, 2'd0, 1'b0, 1'b0);
        // re-request during blinking restarts the sequence
        do_reset(1);
        go(9); i_blink_req = 1'b1;
        go(10); i_blink_req = 1'b0;
        go(69); i_blink_req = 1'b1;
        go(70); i_blink_req = 1'b0;
        go(67);  chk("rr_f2_on", 4'b1110, 2'd0, 1'b0, 1'b1);
        go(99);  chk("rr_f3_off", 4'b1111, 2'd0, 1'b1, 1'b1);
        go(131); chk("rr_f4_on", 4'b1110, 2'd0, 1'b0, 1'b1);
        go(163); chk("rr_f5_off", 4'b1111, 2'd0, 1'b1, 1'b1);
        go(195); chk("rr_f6_on", 4'b1110, 2'd0, 1'b0, 1'b1);
        go(227); chk("rr_scan", 4'b1110, 2'd0, 1'b0, 1'b0);
        // reset mid-blink drops state and any pending request
        do_reset(1);
        go(9); i_blink_req = 1'b1;
        go(10); i_blink_req = 1'b0;
        go(35); chk("mb_off", 4'b1111, 2'd0, 1'b1, 1'b1);
        go(44); i_blink_req = 1'b1;
        go(45); i_blink_req = 1'b0;
        go(49);
        do_reset(1);
        go(1);  chk("mb_e1", 4'b1111, 2'd0, 1'b1, 1'b0);
        go(3);  chk("mb_e3", 4'b1110, 2'd0, 1'b0, 1'b0);
        go(33); chk("mb_e33", 4'b1111, 2'd0, 1'b1, 1'b0);
        go(35); chk("mb_e35", 4'b1110, 2'd0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the vending machine's 7-segment bank. Sources include credit, price and change.
- One shared 2-bit-code segment decoder serves NUM_DIGITS common-anode digits. The block selects which digit code feeds the decoder and drives the matching anode.
- Adds anti-ghosting dead time, per-digit blanking, and a "dispense" blink sequence requested by the vending FSM.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (2..8).
- REFRESH_DIV, 1000, clock cycles per digit slot (>= 2).
- DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off (0 <= DEAD_CYCLES < REFRESH_DIV).
- BLINK_TOGGLES, 3, number of off/on frame pairs per blink request (>= 1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- i_digits, input, 2*NUM_DIGITS, packed digit codes (0..3). Digit d is i_digits[2d+1:2d].
- i_blank_mask, input, NUM_DIGITS, 1 = digit d is never lit.
- i_blink_req, input, 1, single-cycle request to start the blink sequence.
- o_bcd, output, 2, code to the shared segment decoder.
- o_an, output, NUM_DIGITS, active-low one-hot anode enables.
- o_blank, output, 1, 1 when all anodes are off (decoder output gating).
- o_blinking, output, 1, 1 while a blink sequence is active.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst). All outputs are registered.
- Reset values: o_bcd=0, o_an=all 1s, o_blank=1, o_blinking=0. Internal state reset to slot counter=0, digit index=0, snapshot=0, FSM=SCAN, blink count=0.
- Slot timing: edge 1 is the first rising edge with rst=0.
  - After edge k, outputs reflect absolute position p=k-1.
  - Slot position s = p mod REFRESH_DIV.
  - Digit index = (p div REFRESH_DIV) mod NUM_DIGITS, wrapping from NUM_DIGITS-1 to 0.
  - Frame = NUM_DIGITS*REFRESH_DIV cycles.
- Dead time: for s < DEAD_CYCLES, o_an is all 1s and o_blank=1. o_bcd already carries the new digit's code.
- Lit window: for s >= DEAD_CYCLES, o_an[idx]=0 and all other bits are 1, unless the digit is suppressed (mask or blink-off frame). When suppressed, all anodes are 1 and o_blank=1.
- Snapshot:
  - i_digits and i_blank_mask are captured into internal registers on the edge that starts each frame (p mod frame == 0, including edge 1).
  - o_bcd and masking use only the snapshot, so mid-frame input changes never tear a frame.
- FSM states:
  - SCAN: normal display.
  - BLINK_OFF: entire frame blanked.
  - BLINK_ON: frame displayed normally.
- Transitions, evaluated at the frame-start edge:
  - SCAN -> BLINK_OFF if a request is pending.
  - BLINK_OFF -> BLINK_ON.
  - BLINK_ON -> BLINK_OFF if the completed pair count < BLINK_TOGGLES, else -> SCAN.
- Request latch:
  - i_blink_req sets a pending flag on any cycle. The flag is consumed at the next frame start.
  - A request arriving while blinking restarts the sequence: at the next frame start the state goes to BLINK_OFF with the pair count cleared.
  - A request on the same edge as a frame start is pending and consumed at that edge.
- o_blinking=1 in BLINK_OFF and BLINK_ON.
- Reset mid-operation: rst=1 on any edge returns every register to its reset value on that edge and drops any pending request. Timing restarts at edge 1 after release.
- Counters use minimal widths ($clog2). There is no overflow beyond the modulo wraps defined above.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_TOGGLES=2 (frame = 32 cycles).
- Reset check: hold rst 3 cycles with i_digits=8'hE4 -> o_an=4'b1111, o_bcd=0, o_blank=1, o_blinking=0 throughout.
- Scan order: release rst with i_digits=8'hE4 (d0=0, d1=1, d2=2, d3=3), mask=0.
  - Edges 1-2: o_an=1111.
  - Edges 3-8: o_an=1110, o_bcd=0.
  - Edges 11-16: o_an=1101, o_bcd=1.
  - Edges 27-32: o_an=0111, o_bcd=3.
  - Edge 35: o_an=1110 again.
- Snapshot: change i_digits to 8'h1B at edge 12 -> frame 0 still shows 0,1,2,3; frame 1 (edges 33-64) shows 3,2,1,0.
- Blank mask: i_blank_mask=4'b0100 -> during digit 2's lit window o_an=1111 and o_blank=1; other digits are unaffected.
- Blink: pulse i_blink_req at edge 10 -> o_blinking=1 from edge 33.
  - Frames 1 and 3 fully blanked; frames 2 and 4 displayed.
  - SCAN resumes at edge 161 with o_blinking=0.
  - A re-request at edge 70 causes blanking to restart in the frame starting at edge 97.
- Reset mid-blink: assert rst at edge 50 -> outputs return to reset values at that edge and o_blinking=0. After release, normal scan resumes with no blink.
